// File: rtl/collision_event_scheduler.sv
// Per-frame collision controller: folds per-pixel crash flags into sticky records,
// then at startOfFrame dispatches one clean set of action pulses and at most one bubble pop.
module collision_event_scheduler #(
  parameter int NUM_BUBBLES = 8,
  parameter int BID_W       = 3,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             charCrashLeft,
  input  logic             charCrashRight,
  input  logic             arrowHitTop,
  input  logic             arrowHitBubble,
  input  logic             bubbleHitChar,
  input  logic [BID_W-1:0] bubbleId,
  input  logic             popAck,
  output logic             charBlockLeft,
  output logic             charBlockRight,
  output logic             arrowReset,
  output logic             lifeLost,
  output logic             popReq,
  output logic [BID_W-1:0] popId,
  output logic             popTimeout,
  output logic             frameOverrun
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    POP      = 2'd2
  } state_t;

  localparam logic [9:0] TO_LAST = 10'(ACK_TIMEOUT - 1);

  state_t                 state_r;
  logic                   accL_r, accR_r, accTop_r, accArrowBub_r, accChar_r;
  logic [NUM_BUBBLES-1:0] hitMask_r;
  logic [NUM_BUBBLES-1:0] snapMask_r;
  logic                   snapChar_r;
  logic [9:0]             ackCnt_r;
  logic [NUM_BUBBLES-1:0] setMask_s;
  logic                   bidValid_s;
  logic                   takeSnap_s;
  logic [BID_W-1:0]       lowId_s;

  function automatic logic [BID_W-1:0] lowestSet(input logic [NUM_BUBBLES-1:0] mask);
    lowestSet = '0;
    for (int i = NUM_BUBBLES - 1; i >= 0; i--) begin
      if (mask[i]) lowestSet = BID_W'(i);
    end
  endfunction

  // Decode the per-pixel bubble hit and the pop candidate from the snapshot.
  always_comb begin
    setMask_s  = '0;
    bidValid_s = (int'(bubbleId) < NUM_BUBBLES);
    takeSnap_s = startOfFrame && (state_r == IDLE);
    if (arrowHitBubble && bidValid_s) begin
      setMask_s[bubbleId] = 1'b1;
    end else begin
      setMask_s = '0;
    end
    lowId_s = lowestSet(snapMask_r);
  end

  // Sticky accumulators; a snapshot restarts them with the flags of the SOF cycle itself.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      accL_r        <= 1'b0;
      accR_r        <= 1'b0;
      accTop_r      <= 1'b0;
      accArrowBub_r <= 1'b0;
      accChar_r     <= 1'b0;
      hitMask_r     <= '0;
    end else if (takeSnap_s) begin
      accL_r        <= charCrashLeft;
      accR_r        <= charCrashRight;
      accTop_r      <= arrowHitTop;
      accArrowBub_r <= arrowHitBubble;
      accChar_r     <= bubbleHitChar;
      hitMask_r     <= setMask_s;
    end else begin
      accL_r        <= accL_r | charCrashLeft;
      accR_r        <= accR_r | charCrashRight;
      accTop_r      <= accTop_r | arrowHitTop;
      accArrowBub_r <= accArrowBub_r | arrowHitBubble;
      accChar_r     <= accChar_r | bubbleHitChar;
      hitMask_r     <= hitMask_r | setMask_s;
    end
  end

  // Frame FSM: snapshot, one-cycle dispatch, then the pop handshake with timeout.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r        <= IDLE;
      snapMask_r     <= '0;
      snapChar_r     <= 1'b0;
      ackCnt_r       <= 10'd0;
      charBlockLeft  <= 1'b0;
      charBlockRight <= 1'b0;
      arrowReset     <= 1'b0;
      lifeLost       <= 1'b0;
      popReq         <= 1'b0;
      popId          <= '0;
      popTimeout     <= 1'b0;
      frameOverrun   <= 1'b0;
    end else begin
      charBlockLeft  <= 1'b0;
      charBlockRight <= 1'b0;
      arrowReset     <= 1'b0;
      lifeLost       <= 1'b0;
      popTimeout     <= 1'b0;
      frameOverrun   <= startOfFrame && (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (startOfFrame) begin
            // The pulses are loaded from the same values the snapshot captures.
            snapMask_r     <= hitMask_r;
            snapChar_r     <= accChar_r;
            charBlockLeft  <= accL_r;
            charBlockRight <= accR_r;
            arrowReset     <= accTop_r | accArrowBub_r;
            lifeLost       <= accChar_r;
            state_r        <= DISPATCH;
          end else begin
            state_r <= IDLE;
          end
        end
        DISPATCH: begin
          if (!snapChar_r && (snapMask_r != '0)) begin
            popReq   <= 1'b1;
            popId    <= lowId_s;
            ackCnt_r <= 10'd0;
            state_r  <= POP;
          end else begin
            state_r <= IDLE;
          end
        end
        POP: begin
          if (popAck) begin
            popReq  <= 1'b0;
            state_r <= IDLE;
          end else if (ackCnt_r == TO_LAST) begin
            popReq     <= 1'b0;
            popTimeout <= 1'b1;
            state_r    <= IDLE;
          end else begin
            ackCnt_r <= ackCnt_r + 10'd1;
          end
        end
        default: begin
          popReq  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_event_scheduler.sv
// Directed bench for collision_event_scheduler: per-frame vector table plus
// hand sequences for overrun merging and reset during a pop handshake.
module tb_collision_event_scheduler;
  localparam int NB = 6;
  localparam int BW = 3;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic resetN, startOfFrame, charCrashLeft, charCrashRight, arrowHitTop;
  logic arrowHitBubble, bubbleHitChar, popAck;
  logic [BW-1:0] bubbleId, popId;
  logic charBlockLeft, charBlockRight, arrowReset, lifeLost, popReq, popTimeout, frameOverrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  collision_event_scheduler #(.NUM_BUBBLES(NB), .BID_W(BW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .charCrashLeft(charCrashLeft), .charCrashRight(charCrashRight),
    .arrowHitTop(arrowHitTop), .arrowHitBubble(arrowHitBubble),
    .bubbleHitChar(bubbleHitChar), .bubbleId(bubbleId), .popAck(popAck),
    .charBlockLeft(charBlockLeft), .charBlockRight(charBlockRight),
    .arrowReset(arrowReset), .lifeLost(lifeLost), .popReq(popReq),
    .popId(popId), .popTimeout(popTimeout), .frameOverrun(frameOverrun)
  );

  // flags = {left, right, top, arrowBubble, bubbleChar}; expPulse = {blockL, blockR, arrowReset, lifeLost}
  typedef struct {
    logic [4:0] flags;
    logic [2:0] bidA;
    logic [2:0] bidB;
    int         nPix;
    int         ackDelay;
    logic [3:0] expPulse;
    logic       expPop;
    logic [2:0] expId;
    int         expHigh;
    int         expTo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setFlags(input logic [4:0] f, input logic [2:0] b);
    {charCrashLeft, charCrashRight, arrowHitTop, arrowHitBubble, bubbleHitChar} = f;
    bubbleId = b;
  endtask

  function automatic logic [3:0] pulses();
    return {charBlockLeft, charBlockRight, arrowReset, lifeLost};
  endfunction

  task automatic runVec(input vec_t v);
    int high;
    int toCnt;
    int ovr;
    for (int p = 0; p < v.nPix; p++) begin
      setFlags(v.flags, (p == 0) ? v.bidA : v.bidB);
      tick();
    end
    setFlags(5'b00000, 3'd0);
    tick();
    chk("quiet_before_sof", 32'({pulses(), popReq}), 32'd0);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("dispatch_pulses", 32'(pulses()), 32'(v.expPulse));
    tick();
    chk("pulses_one_cycle", 32'(pulses()), 32'd0);
    chk("pop_start", 32'(popReq), 32'(v.expPop));
    if (v.expPop) chk("pop_id", 32'(popId), 32'(v.expId));
    high  = 0;
    toCnt = 0;
    ovr   = 0;
    for (int c = 0; c < 10; c++) begin
      if (popReq) begin
        high++;
        chk("pop_id_stable", 32'(popId), 32'(v.expId));
      end
      if (popTimeout) toCnt++;
      if (frameOverrun) ovr++;
      popAck = (c == v.ackDelay) ? 1'b1 : 1'b0;
      tick();
    end
    popAck = 1'b0;
    chk("pop_high_cycles", 32'(high), 32'(v.expHigh));
    chk("pop_timeout_pulses", 32'(toCnt), 32'(v.expTo));
    chk("no_overrun", 32'(ovr), 32'd0);
  endtask

  initial begin
    int ovCount;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    popAck       = 1'b0;
    setFlags(5'b00000, 3'd0);

    vecs[0] = '{5'b10000, 3'd0, 3'd0, 3, -1, 4'b1000, 1'b0, 3'd0, 0, 0}; // left crash, 3 pixels
    vecs[1] = '{5'b01100, 3'd0, 3'd0, 1, -1, 4'b0110, 1'b0, 3'd0, 0, 0}; // right + top
    vecs[2] = '{5'b00010, 3'd5, 3'd2, 2,  3, 4'b0010, 1'b1, 3'd2, 4, 0}; // ids 5,2; ack on last cycle wins
    vecs[3] = '{5'b00010, 3'd5, 3'd5, 1, -1, 4'b0010, 1'b1, 3'd5, 4, 1}; // timeout
    vecs[4] = '{5'b00011, 3'd1, 3'd1, 1,  0, 4'b0011, 1'b0, 3'd0, 0, 0}; // life lost suppresses pop
    vecs[5] = '{5'b00010, 3'd0, 3'd0, 1,  0, 4'b0010, 1'b1, 3'd0, 1, 0}; // immediate ack
    vecs[6] = '{5'b00010, 3'd7, 3'd7, 1, -1, 4'b0010, 1'b0, 3'd0, 0, 0}; // out-of-range id
    vecs[7] = '{5'b00000, 3'd0, 3'd0, 1,  0, 4'b0000, 1'b0, 3'd0, 0, 0}; // empty frame, stray ack
    vecs[8] = '{5'b11000, 3'd0, 3'd0, 2, -1, 4'b1100, 1'b0, 3'd0, 0, 0}; // left and right together
    vecs[9] = '{5'b00010, 3'd7, 3'd4, 2,  1, 4'b0010, 1'b1, 3'd4, 2, 0}; // bad id then id 4

    repeat (3) tick();
    chk("reset_outputs", 32'({pulses(), popReq, popId, popTimeout, frameOverrun}), 32'd0);
    resetN = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) runVec(vecs[i]);

    // Overrun: SOF arrives during POP; the right-crash events on either side merge.
    setFlags(5'b01010, 3'd3);
    tick();
    setFlags(5'b00000, 3'd0);
    tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("ovr_dispatch", 32'(pulses()), 32'(4'b0110));
    setFlags(5'b01000, 3'd0);
    tick();
    setFlags(5'b00000, 3'd0);
    chk("ovr_pop_req", 32'(popReq), 32'd1);
    chk("ovr_pop_id", 32'(popId), 32'd3);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("ovr_pulse", 32'(frameOverrun), 32'd1);
    setFlags(5'b01000, 3'd0);
    tick();
    setFlags(5'b00000, 3'd0);
    ovCount = 0;
    for (int c = 0; c < 8; c++) begin
      if (frameOverrun) ovCount++;
      tick();
    end
    chk("ovr_single_pulse", 32'(ovCount), 32'd0);
    chk("ovr_pop_done", 32'(popReq), 32'd0);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("ovr_merged", 32'(pulses()), 32'(4'b0100));
    tick();
    chk("ovr_no_pop", 32'(popReq), 32'd0);
    repeat (3) tick();

    // Reset in the middle of a handshake, then an event in the SOF cycle itself.
    setFlags(5'b00010, 3'd2);
    tick();
    setFlags(5'b00000, 3'd0);
    tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    chk("rst_pop_up", 32'(popReq), 32'd1);
    resetN = 1'b0;
    #1;
    chk("rst_async_drop", 32'(popReq), 32'd0);
    tick();
    tick();
    resetN = 1'b1;
    tick();
    setFlags(5'b10000, 3'd0);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    setFlags(5'b00000, 3'd0);
    chk("rst_sof_quiet", 32'(pulses()), 32'd0);
    tick();
    chk("rst_no_pop", 32'(popReq), 32'd0);
    repeat (3) tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("sof_cycle_event_late", 32'(pulses()), 32'(4'b1000));
    tick();
    chk("late_pulse_once", 32'(pulses()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/collision_event_scheduler.md
Name: collision_event_scheduler

Overview:
- Per-frame controller placed after the pixel-level border/collision detector.
- During the raster scan it accumulates the single-pixel crash flags into sticky per-frame records.
- At startOfFrame it snapshots those records, issues one-cycle action pulses to the character, arrow and life logic, and runs a request/acknowledge handshake with the bubble manager to pop at most one hit bubble.
- Because it works from per-frame snapshots, object-moving logic sees one clean event per frame rather than a burst of per-pixel flags.

Parameters:
- NUM_BUBBLES, 8, number of bubble slots; bubble ids 0..NUM_BUBBLES-1.
- BID_W, 3, width of the bubble id; must equal $clog2(NUM_BUBBLES), minimum 1.
- ACK_TIMEOUT, 64, maximum cycles popReq may stay high waiting for popAck; allowed range 1..1023.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse at the start of each frame.
- charCrashLeft  in  1  per-pixel flag: character touching the left border.
- charCrashRight  in  1  per-pixel flag: character touching the right border.
- arrowHitTop  in  1  per-pixel flag: arrow touching the top border.
- arrowHitBubble  in  1  per-pixel flag: arrow overlapping a bubble.
- bubbleHitChar  in  1  per-pixel flag: bubble overlapping the character.
- bubbleId  in  BID_W  id of the bubble drawn at the current pixel; valid only while arrowHitBubble=1.
- popAck  in  1  bubble manager accepts the pop request.
- charBlockLeft  out  1  one-cycle pulse: block leftward motion.
- charBlockRight  out  1  one-cycle pulse: block rightward motion.
- arrowReset  out  1  one-cycle pulse: retract the arrow.
- lifeLost  out  1  one-cycle pulse: the character was hit.
- popReq  out  1  pop request, held until acknowledged or timed out.
- popId  out  BID_W  id of the bubble to pop; stable while popReq=1.
- popTimeout  out  1  one-cycle pulse: pop request abandoned.
- frameOverrun  out  1  one-cycle pulse: startOfFrame arrived while the FSM was not in IDLE.

Behaviour:
- Reset: all outputs 0; all accumulators, snapshot, timeout counter and FSM cleared; FSM=IDLE.
- Accumulators: sticky bits accL, accR, accTop, accArrowBub, accChar, plus hitMask[NUM_BUBBLES].
  - Each bit is set on any cycle its input flag is 1.
  - hitMask[bubbleId] is set when arrowHitBubble=1 and bubbleId<NUM_BUBBLES.
  - An out-of-range bubbleId does not set hitMask but still sets accArrowBub.
- startOfFrame (SOF) in IDLE:
  - Copy the accumulators into the snapshot and clear the accumulators.
  - Flags asserted in the SOF cycle itself land in the new (cleared) accumulators, not the snapshot.
  - FSM goes to DISPATCH.
- SOF while not IDLE:
  - No snapshot is taken and accumulators are not cleared; events from both frames merge.
  - frameOverrun pulses in the next cycle.
- DISPATCH (one cycle), output pulses (registered, high exactly this cycle):
  - charBlockLeft=snapL, charBlockRight=snapR.
  - arrowReset=snapTop|snapArrowBub.
  - lifeLost=snapChar.
  - Left and right may pulse together.
- DISPATCH next state:
  - snapChar=1: IDLE, no pop (level restart is owned elsewhere).
  - snapChar=0 and snap hitMask nonzero: POP, with popId = lowest set index.
  - Otherwise: IDLE.
  - Only one bubble is popped per frame; remaining mask bits are discarded.
- POP:
  - popReq=1 and popId held constant.
  - The timeout counter starts at 0 and increments each cycle popReq=1 and popAck=0.
  - popAck=1 sampled: popReq=0 in the next cycle, go IDLE.
  - Counter reaches ACK_TIMEOUT with no ack: popReq=0 in the next cycle, popTimeout pulses once, go IDLE.
  - If popAck arrives in the same cycle the counter reaches ACK_TIMEOUT, the ack wins; no popTimeout.
- popAck outside POP is ignored.
- Asynchronous reset mid-handshake drops popReq immediately.
- Latency:
  - SOF at cycle T: action pulses at T+1, popReq first high at T+2.
  - Minimum turnaround is back in IDLE at T+3 (ack sampled at T+2).

Test Plan:
- Left-crash only: charCrashLeft pulses 3 pixels mid-frame, then SOF -> exactly one charBlockLeft pulse at SOF+1; all other outputs 0.
- Two bubbles hit: arrowHitBubble with bubbleId=5, then 2; SOF; popAck 3 cycles after popReq rises -> arrowReset at SOF+1, popReq at SOF+2 with popId=2, popReq low one cycle after ack; no pop for id 5.
- Timeout: ACK_TIMEOUT=4, a bubble hit and popAck tied low -> popReq high for 4 cycles, then low, with one popTimeout pulse.
- Life lost: bubbleHitChar and arrowHitBubble (id 1) in the same frame -> lifeLost and arrowReset pulse at SOF+1; popReq never rises.
- Overrun: SOF issued while in POP -> frameOverrun pulse; the following SOF dispatches the merged events (e.g. accR from both frames gives a single charBlockRight pulse).
- Reset: resetN low during POP -> popReq drops immediately; after release, SOF with no events gives no output pulses; an event in the SOF cycle is reported one frame later.
